// File: rtl/col_pack_unit.sv
// Column field packer: pulls a (start, width) byte field out of each row's read beats
// and packs the fields densely into 16-byte write words. `COL_PACK_STRB_EN adds o_wr_strb.
module col_pack_unit #(
  parameter int DATA_BYTES = 16,
  parameter int OFF_BITS   = 4,
  parameter int BEAT_BITS  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_desc_valid,
  output logic                    o_desc_ready,
  input  logic [OFF_BITS-1:0]     i_desc_start,
  input  logic [4:0]              i_desc_width,
  input  logic [BEAT_BITS-1:0]    i_desc_beats,
  input  logic                    i_desc_last,
  input  logic                    i_rd_valid,
  output logic                    o_rd_ready,
  input  logic [8*DATA_BYTES-1:0] i_rd_data,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [8*DATA_BYTES-1:0] o_wr_data,
  output logic [4:0]              o_wr_bytes,
`ifdef COL_PACK_STRB_EN
  output logic [DATA_BYTES-1:0]   o_wr_strb,
`endif
  output logic                    o_busy
);
  localparam int DW     = 8*DATA_BYTES;
  localparam int FILL_W = OFF_BITS + 1;
  localparam logic [4:0]        FULL_W = 5'(DATA_BYTES);
  localparam logic [FILL_W-1:0] FULL_F = FILL_W'(DATA_BYTES);

  typedef enum logic [2:0] {IDLE, COLLECT, MERGE, EMIT, EMIT_TAIL} state_t;

  state_t                state_q, state_d;
  logic [OFF_BITS-1:0]   s_q, s_d;
  logic [4:0]            w_q, w_d;
  logic [BEAT_BITS-1:0]  cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  rd_ready_q, rd_ready_d;
  logic [2*DW-1:0]       win_q, win_d;
  logic [2*DW-1:0]       acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [2*DW-1:0]       fmask, field;
  logic [DW-1:0]         tmask;

  // Field bytes right-aligned and masked to the row width; tail mask covers bytes below fill.
  always_comb begin
    fmask = '0;
    tmask = '0;
    for (int k = 0; k < 2*DATA_BYTES; k++) fmask[8*k +: 8] = (5'(k) < w_q) ? 8'hFF : 8'h00;
    for (int k = 0; k < DATA_BYTES; k++)   tmask[8*k +: 8] = (5'(k) < 5'(fill_q)) ? 8'hFF : 8'h00;
    field = (win_q >> {s_q, 3'b000}) & fmask;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    win_d   = win_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (i_desc_valid) begin
        s_d     = i_desc_start;
        w_d     = (i_desc_width > FULL_W) ? FULL_W : i_desc_width;
        cnt_d   = (i_desc_beats == '0) ? BEAT_BITS'(1) : i_desc_beats;
        idx_d   = '0;
        last_d  = i_desc_last;
        win_d   = '0;
        state_d = COLLECT;
      end
      COLLECT: if (i_rd_valid && rd_ready_q) begin
        if (idx_q == 2'd0) win_d[DW-1:0]    = i_rd_data;
        if (idx_q == 2'd1) win_d[2*DW-1:DW] = i_rd_data;
        if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == BEAT_BITS'(1)) state_d = MERGE;
      end
      MERGE: begin
        // Bytes at and above fill are always zero, so OR-ing appends cleanly.
        acc_d  = acc_q | (field << {fill_q, 3'b000});
        fill_d = fill_q + FILL_W'(w_q);
        if (fill_d >= FULL_F)             state_d = EMIT;
        else if (last_q && fill_d != '0)  state_d = EMIT_TAIL;
        else                              state_d = IDLE;
      end
      EMIT: if (i_wr_ready) begin
        acc_d   = acc_q >> DW;
        fill_d  = fill_q - FULL_F;
        state_d = (last_q && fill_d != '0) ? EMIT_TAIL : IDLE;
      end
      EMIT_TAIL: if (i_wr_ready) begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      rd_ready_q <= 1'b0;
      win_q      <= '0;
      acc_q      <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      rd_ready_q <= rd_ready_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
    end
  end

  assign o_desc_ready = (state_q == IDLE);
  assign o_rd_ready   = rd_ready_q;
  assign o_wr_valid   = (state_q == EMIT) || (state_q == EMIT_TAIL);
  assign o_busy       = (state_q != IDLE) || (fill_q != '0);

  always_comb begin
    o_wr_data  = '0;
    o_wr_bytes = '0;
    if (state_q == EMIT) begin
      o_wr_data  = acc_q[DW-1:0];
      o_wr_bytes = FULL_W;
    end else if (state_q == EMIT_TAIL) begin
`ifdef COL_PACK_STRB_EN
      o_wr_data  = acc_q[DW-1:0];
`else
      o_wr_data  = acc_q[DW-1:0] & tmask;
`endif
      o_wr_bytes = 5'(fill_q);
    end
  end

`ifdef COL_PACK_STRB_EN
  always_comb begin
    o_wr_strb = '0;
    if (state_q == EMIT) o_wr_strb = '1;
    else if (state_q == EMIT_TAIL)
      for (int k = 0; k < DATA_BYTES; k++) o_wr_strb[k] = (5'(k) < 5'(fill_q));
  end
`endif
endmodule

// File: tb/tb_col_pack_unit.sv
// Directed bench for col_pack_unit: table of rows with expected packed words,
// plus hand sequences for back-pressure and mid-row reset.
module tb_col_pack_unit;
  localparam logic [127:0] B0 = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] B1 = 128'h2F2E2D2C2B2A29282726252423222120;

  logic         gclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         desc_valid = 1'b0, desc_ready, desc_last = 1'b0;
  logic [3:0]   desc_start = '0;
  logic [4:0]   desc_width = '0, desc_beats = '0;
  logic         rd_valid = 1'b0, rd_ready;
  logic [127:0] rd_data = '0;
  logic         wr_valid, wr_ready = 1'b1;
  logic [127:0] wr_data;
  logic [4:0]   wr_bytes;
  logic [15:0]  wr_strb;
  logic         busy;

  always #5 gclk = ~gclk;

  col_pack_unit dut (
    .i_clk(gclk), .i_rst_n(rst_n),
    .i_desc_valid(desc_valid), .o_desc_ready(desc_ready),
    .i_desc_start(desc_start), .i_desc_width(desc_width),
    .i_desc_beats(desc_beats), .i_desc_last(desc_last),
    .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_data(rd_data),
    .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
    .o_wr_data(wr_data), .o_wr_bytes(wr_bytes),
`ifdef COL_PACK_STRB_EN
    .o_wr_strb(wr_strb),
`endif
    .o_busy(busy)
  );
`ifndef COL_PACK_STRB_EN
  assign wr_strb = '0;
`endif

  typedef struct { int grp; logic [3:0] s; logic [4:0] w; logic [4:0] b; logic last; } row_t;
  typedef struct { int grp; logic [127:0] data; logic [4:0] bytes; logic [15:0] strb; } word_t;

  localparam int NROWS = 9, NWORDS = 6, NGRP = 7;
  row_t  rows  [NROWS];
  word_t words [NWORDS];
  word_t q [$];
  int nvec = 0, nerr = 0;

  // Capture each write handshake; outputs are stable at the falling edge.
  always @(negedge gclk)
    if (rst_n && wr_valid && wr_ready) q.push_back('{0, wr_data, wr_bytes, wr_strb});

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_desc(logic [3:0] s, logic [4:0] w, logic [4:0] b, logic last);
    int t = 0;
    @(negedge gclk);
    desc_valid = 1'b1; desc_start = s; desc_width = w; desc_beats = b; desc_last = last;
    while (!desc_ready && t < 200) begin @(negedge gclk); t++; end
    chk("desc_accept", 128'(desc_ready), 128'(1'b1));
    @(negedge gclk);
    desc_valid = 1'b0;
  endtask

  task automatic send_beat(logic [127:0] d);
    int t = 0;
    rd_valid = 1'b1; rd_data = d;
    while (!rd_ready && t < 200) begin @(negedge gclk); t++; end
    chk("beat_accept", 128'(rd_ready), 128'(1'b1));
    @(negedge gclk);
    rd_valid = 1'b0;
  endtask

  task automatic send_row(row_t r);
    int nb;
    nb = (r.b == 0) ? 1 : int'(r.b);
    send_desc(r.s, r.w, r.b, r.last);
    for (int i = 0; i < nb; i++)
      send_beat(i == 0 ? B0 : (i == 1 ? B1 : {16{8'hEE}}));
  endtask

  task automatic wait_words(int n);
    int t = 0;
    while (q.size() < n && t < 300) begin @(negedge gclk); t++; end
    repeat (6) @(negedge gclk);
    chk("word_count", 128'(q.size()), 128'(n));
  endtask

  task automatic cmp_word(string nm, logic [127:0] d, logic [4:0] by, logic [15:0] st);
    word_t g;
    if (q.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: got no word expected %h", nm, d);
    end else begin
      g = q.pop_front();
      chk({nm, "_data"}, g.data, d);
      chk({nm, "_bytes"}, 128'(g.bytes), 128'(by));
`ifdef COL_PACK_STRB_EN
      chk({nm, "_strb"}, 128'(g.strb), 128'(st));
`endif
    end
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_busy"}, 128'(busy), 128'(1'b0));
    chk({nm, "_dready"}, 128'(desc_ready), 128'(1'b1));
    chk({nm, "_rready"}, 128'(rd_ready), 128'(1'b0));
    chk({nm, "_wvalid"}, 128'(wr_valid), 128'(1'b0));
    chk({nm, "_wdata"}, wr_data, 128'h0);
    chk({nm, "_wbytes"}, 128'(wr_bytes), 128'h0);
  endtask

  initial begin
    int n, t;
    rows[0] = '{0, 4'd0,  5'd4,  5'd1, 1'b0};
    rows[1] = '{0, 4'd0,  5'd4,  5'd1, 1'b0};
    rows[2] = '{0, 4'd0,  5'd4,  5'd1, 1'b0};
    rows[3] = '{0, 4'd0,  5'd4,  5'd1, 1'b1};
    rows[4] = '{1, 4'd14, 5'd4,  5'd2, 1'b1};
    rows[5] = '{2, 4'd0,  5'd16, 5'd2, 1'b1};
    rows[6] = '{3, 4'd0,  5'd5,  5'd1, 1'b1};
    rows[7] = '{4, 4'd2,  5'd20, 5'd2, 1'b1};
    rows[8] = '{5, 4'd1,  5'd2,  5'd0, 1'b1};
    words[0] = '{0, 128'h13121110131211101312111013121110, 5'd16, 16'hFFFF};
    words[1] = '{1, 128'h21201F1E, 5'd4, 16'h000F};
    words[2] = '{2, B0, 5'd16, 16'hFFFF};
    words[3] = '{3, 128'h1413121110, 5'd5, 16'h001F};
    words[4] = '{4, 128'h21201F1E1D1C1B1A1918171615141312, 5'd16, 16'hFFFF};
    words[5] = '{5, 128'h1211, 5'd2, 16'h0003};

    repeat (3) @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
    chk_idle("reset");

    for (int g = 0; g < NGRP; g++) begin
      if (g == 6) begin
        send_desc(4'd3, 5'd0, 5'd1, 1'b1);   // zero-width last row with empty accumulator
        send_beat(B0);
      end
      for (int r = 0; r < NROWS; r++) if (rows[r].grp == g) send_row(rows[r]);
      n = 0;
      for (int w = 0; w < NWORDS; w++) if (words[w].grp == g) n++;
      wait_words(n);
      for (int w = 0; w < NWORDS; w++)
        if (words[w].grp == g) cmp_word($sformatf("grp%0d", g), words[w].data, words[w].bytes, words[w].strb);
      chk_idle($sformatf("grp%0d_end", g));
    end

    // Back-pressure: first word held for 5 cycles, nothing accepted meanwhile.
    wr_ready = 1'b0;
    for (int r = 0; r < 3; r++) send_row('{9, 4'd0, 5'd6, 5'd1, (r == 2)});
    t = 0;
    while (!wr_valid && t < 200) begin @(negedge gclk); t++; end
    chk("stall_valid", 128'(wr_valid), 128'(1'b1));
    repeat (5) begin
      chk("stall_data", wr_data, 128'h13121110151413121110151413121110);
      chk("stall_bytes", 128'(wr_bytes), 128'(5'd16));
      chk("stall_rready", 128'(rd_ready), 128'(1'b0));
      chk("stall_dready", 128'(desc_ready), 128'(1'b0));
      @(negedge gclk);
    end
    wr_ready = 1'b1;
    wait_words(2);
    cmp_word("stall_w0", 128'h13121110151413121110151413121110, 5'd16, 16'hFFFF);
    cmp_word("stall_tail", 128'h1514, 5'd2, 16'h0003);
    chk_idle("stall_end");

    // Reset mid-COLLECT with residual fill: everything in flight is dropped.
    send_row('{9, 4'd0, 5'd5, 5'd1, 1'b0});
    repeat (3) @(negedge gclk);
    chk("resid_busy", 128'(busy), 128'(1'b1));
    send_desc(4'd0, 5'd16, 5'd2, 1'b1);
    send_beat({16{8'hAA}});
    rst_n = 1'b0;
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
    chk_idle("midreset");
    chk("midreset_nowords", 128'(q.size()), 128'h0);
    q.delete();
    send_row('{9, 4'd0, 5'd3, 5'd1, 1'b1});
    wait_words(1);
    cmp_word("post_reset", 128'h121110, 5'd3, 16'h0007);
    chk_idle("post_reset_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
